// File: rtl/quant_tile_ctrl_if.sv
// quant_tile_ctrl_if
// Bundles the tile-stream handshake and the quantizer side-band of
// quant_tile_ctrl.
//   master : tile producer plus quantizer (drives i_* and i_q_index)
//   slave  : quant_tile_ctrl (drives o_*)
// Signals:
//   i_start, i_valid, i_act[31:0], i_last, o_ready      tile load stream
//   o_q_max[31:0], o_q_act[31:0], i_q_index[7:0]        quantizer hookup
//   o_valid, o_index[7:0], o_busy, o_done               result / status
interface quant_tile_ctrl_if;
  logic        i_start;
  logic        i_valid;
  logic [31:0] i_act;
  logic        i_last;
  logic        o_ready;
  logic [31:0] o_q_max;
  logic [31:0] o_q_act;
  logic [7:0]  i_q_index;
  logic        o_valid;
  logic [7:0]  o_index;
  logic        o_busy;
  logic        o_done;

  modport master (
    output i_start, i_valid, i_act, i_last, i_q_index,
    input  o_ready, o_q_max, o_q_act, o_valid, o_index, o_busy, o_done
  );

  modport slave (
    input  i_start, i_valid, i_act, i_last, i_q_index,
    output o_ready, o_q_max, o_q_act, o_valid, o_index, o_busy, o_done
  );
endinterface

// File: rtl/quant_tile_ctrl.sv
// quant_tile_ctrl
// Two-pass tile scheduler in front of the quantizer datapath.
//   LOAD  : buffers 1..DEPTH float32 activations and tracks the largest
//           finite non-negative value.
//   DRAIN : holds that maximum on o_q_max and replays the buffered
//           activations on o_q_act, one per cycle.
//   FLUSH : waits out the quantizer latency, then pulses o_done.
// o_valid is the issue strobe delayed by Q_LATENCY so that it lines up with
// the quantizer's i_q_index, which is forwarded unchanged on o_index.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      quant_tile_ctrl_if.slave (stream, quantizer and status signals)
module quant_tile_ctrl #(
  parameter int DEPTH     = 16,
  parameter int Q_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  quant_tile_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (Q_LATENCY > 1) ? $clog2(Q_LATENCY) : 1;

  // 256.0: unit substituted when nothing positive was seen, so the
  // quantizer never divides by zero.
  localparam logic [31:0] UNIT_256 = 32'h43800000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [30:0]   max_r;
  logic [31:0]   act_r;
  logic [FW-1:0] fl_cnt;
  logic          done_r;
  logic [31:0]   tile_buf [DEPTH];

  logic          accept;
  logic          last_beat;
  logic          issue;
  logic          last_issue;
  logic [30:0]   key;

  assign accept     = (state == S_LOAD) && bus.i_valid;
  // Auto-terminate on the DEPTH-th beat regardless of i_last.
  assign last_beat  = bus.i_last || (count == CW'(DEPTH - 1));
  assign issue      = (state == S_DRAIN);
  assign last_issue = ({1'b0, rd_ptr} == (count - CW'(1)));

  // Negative values, inf and NaN are masked to zero. For non-negative
  // finite floats the magnitude bits order the same as unsigned integers,
  // denormals included.
  assign key = (!bus.i_act[31] && (bus.i_act[30:23] != 8'hFF)) ? bus.i_act[30:0] : '0;

  // Tile storage is not reset; only entries below count are ever replayed.
  always_ff @(posedge clk) begin
    if (accept) tile_buf[count[AW-1:0]] <= bus.i_act;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      count  <= '0;
      rd_ptr <= '0;
      max_r  <= '0;
      act_r  <= '0;
      fl_cnt <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            count  <= '0;
            max_r  <= '0;
            rd_ptr <= '0;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            count <= count + CW'(1);
            if (key > max_r) max_r <= key;
            if (last_beat) begin
              state <= S_DRAIN;
              // Entry 0 must already be on o_q_act in the first DRAIN
              // cycle; for a one-beat tile it is being written right now.
              act_r <= (count == '0) ? bus.i_act : tile_buf[0];
            end
          end
        end
        S_DRAIN: begin
          rd_ptr <= rd_ptr + AW'(1);
          if (last_issue) begin
            act_r  <= '0;
            fl_cnt <= '0;
            if (Q_LATENCY == 0) begin
              state  <= S_IDLE;
              done_r <= 1'b1;
            end else begin
              state <= S_FLUSH;
            end
          end else begin
            act_r <= tile_buf[rd_ptr + AW'(1)];
          end
        end
        S_FLUSH: begin
          fl_cnt <= fl_cnt + FW'(1);
          if (fl_cnt == FW'(Q_LATENCY - 1)) begin
            state  <= S_IDLE;
            done_r <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Issue strobe delayed to match the quantizer pipeline.
  generate
    if (Q_LATENCY == 0) begin : g_nodly
      assign bus.o_valid = issue;
    end else begin : g_dly
      logic [Q_LATENCY-1:0] vld_pipe;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe[0] <= issue;
          for (int i = 1; i < Q_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end
      assign bus.o_valid = vld_pipe[Q_LATENCY-1];
    end
  endgenerate

  assign bus.o_ready = (state == S_LOAD);
  assign bus.o_busy  = (state != S_IDLE);
  assign bus.o_done  = done_r;
  assign bus.o_q_max = (max_r == '0) ? UNIT_256 : {1'b0, max_r};
  assign bus.o_q_act = act_r;
  assign bus.o_index = bus.i_q_index;

endmodule

// File: tb/tb_quant_tile_ctrl.sv
// Bench for quant_tile_ctrl: three instances (Q_LATENCY 0, 1, 3) share one
// stimulus stream; each has a behavioural quantizer of matching latency.
module tb_quant_tile_ctrl;
  localparam int DEPTH = 16;
  localparam int LAT [3] = '{0, 1, 3};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic        last  = 1'b0;
  logic [31:0] act   = '0;

  quant_tile_ctrl_if bus0 ();
  quant_tile_ctrl_if bus1 ();
  quant_tile_ctrl_if bus3 ();

  quant_tile_ctrl #(.DEPTH(DEPTH), .Q_LATENCY(0)) u_l0 (.clk(clk), .reset_n(rst_n), .bus(bus0.slave));
  quant_tile_ctrl #(.DEPTH(DEPTH), .Q_LATENCY(1)) u_l1 (.clk(clk), .reset_n(rst_n), .bus(bus1.slave));
  quant_tile_ctrl #(.DEPTH(DEPTH), .Q_LATENCY(3)) u_l3 (.clk(clk), .reset_n(rst_n), .bus(bus3.slave));

  assign bus0.i_start = start;  assign bus1.i_start = start;  assign bus3.i_start = start;
  assign bus0.i_valid = valid;  assign bus1.i_valid = valid;  assign bus3.i_valid = valid;
  assign bus0.i_act   = act;    assign bus1.i_act   = act;    assign bus3.i_act   = act;
  assign bus0.i_last  = last;   assign bus1.i_last  = last;   assign bus3.i_last  = last;

  // float32 bits -> real (inf mapped to a huge value, NaN not used here)
  function automatic real f2r(input logic [31:0] b);
    real m, r;
    int  e;
    e = int'(b[30:23]);
    if (e == 255) return b[31] ? -1.0e39 : 1.0e39;
    m = real'(int'(b[22:0])) / 8388608.0;
    if (e == 0) r = m * (2.0 ** (-126));
    else        r = (1.0 + m) * (2.0 ** (e - 127));
    return b[31] ? -r : r;
  endfunction

  // Behavioural quantizer: floor(act / max * 256) clamped to 0..255
  function automatic logic [7:0] quant(input logic [31:0] a, input logic [31:0] m);
    real r;
    r = f2r(a) / f2r(m) * 256.0;
    if (r < 0.0)    return 8'd0;
    if (r >= 256.0) return 8'd255;
    return 8'($rtoi(r));
  endfunction

  // Positive integer -> float32 bits (exact for v < 2^24)
  function automatic logic [31:0] int2f(input int v);
    logic [31:0] vv;
    int p;
    vv = v;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 31; i++) if (vv[i]) p = i;
    return {1'b0, 8'(127 + p), 23'((vv << (23 - p)) & 32'h007FFFFF)};
  endfunction

  logic [7:0] q1;
  logic [7:0] q3 [3];
  assign bus0.i_q_index = quant(bus0.o_q_act, bus0.o_q_max);
  always @(posedge clk) q1 <= quant(bus1.o_q_act, bus1.o_q_max);
  always @(posedge clk) begin
    q3[0] <= quant(bus3.o_q_act, bus3.o_q_max);
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign bus1.i_q_index = q1;
  assign bus3.i_q_index = q3[2];

  logic [2:0]  ov, od, ob, ordy;
  logic [7:0]  oi [3];
  logic [31:0] om [3];
  logic [31:0] oa [3];
  assign ov   = {bus3.o_valid, bus1.o_valid, bus0.o_valid};
  assign od   = {bus3.o_done,  bus1.o_done,  bus0.o_done};
  assign ob   = {bus3.o_busy,  bus1.o_busy,  bus0.o_busy};
  assign ordy = {bus3.o_ready, bus1.o_ready, bus0.o_ready};
  assign oi[0] = bus0.o_index;  assign oi[1] = bus1.o_index;  assign oi[2] = bus3.o_index;
  assign om[0] = bus0.o_q_max;  assign om[1] = bus1.o_q_max;  assign om[2] = bus3.o_q_max;
  assign oa[0] = bus0.o_q_act;  assign oa[1] = bus1.o_q_act;  assign oa[2] = bus3.o_q_act;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] tile [$];
  logic [7:0]  exp_idx [$];
  logic [7:0]  sb [3][$];

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Drives one tile, pushes expected indices as beats are accepted, then
  // checks o_q_max, the index stream, o_valid timing and o_done timing.
  task automatic run_tile(input string nm, input logic [31:0] exp_max,
                          input bit gap, input bit use_last);
    int n, k, guard, t_acc, d;
    int nv [3];
    bit tog;
    logic [2:0] seen;
    logic [7:0] e;
    n = tile.size();
    t_acc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (ordy !== 3'b111 || ob !== 3'b111) begin
      n_err++;
      $display("FAIL %s start: ready=%b busy=%b want 111/111", nm, ordy, ob);
    end
    k = 0; tog = 1'b0; guard = 0;
    while (k < n && guard < 4 * DEPTH) begin
      guard++;
      tog = ~tog;
      if (gap && !tog) begin
        valid = 1'b0; last = 1'b0;
      end else begin
        valid = 1'b1; act = tile[k]; last = use_last && (k == n - 1);
        if (ordy == 3'b111) begin
          for (int i = 0; i < 3; i++) sb[i].push_back(exp_idx[k]);
          t_acc = cyc;
          k++;
        end
      end
      tick();
    end
    valid = 1'b0; last = 1'b0; act = '0;
    n_cmp++;
    if (k != n) begin
      n_err++;
      $display("FAIL %s load: accepted %0d want %0d", nm, k, n);
    end
    d = t_acc + 1;
    n_cmp++;
    if (ordy !== 3'b000) begin
      n_err++;
      $display("FAIL %s ready_drop: got %b want 000", nm, ordy);
    end
    seen = '0;
    for (int i = 0; i < 3; i++) nv[i] = 0;
    for (int c = 0; c < 4 * DEPTH + 8 && seen != 3'b111; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (ob[i] && !seen[i]) begin
          n_cmp++;
          if (om[i] !== exp_max) begin
            n_err++;
            $display("FAIL %s L%0d q_max: got %h want %h", nm, LAT[i], om[i], exp_max);
          end
        end
        if (ov[i]) begin
          n_cmp++;
          if (sb[i].size() == 0) begin
            n_err++;
            $display("FAIL %s L%0d extra_valid: got valid at cycle %0d want none", nm, LAT[i], cyc);
          end else begin
            e = sb[i].pop_front();
            if (oi[i] !== e) begin
              n_err++;
              $display("FAIL %s L%0d index[%0d]: got %0d want %0d", nm, LAT[i], nv[i], oi[i], e);
            end
          end
          n_cmp++;
          if (cyc != d + LAT[i] + nv[i]) begin
            n_err++;
            $display("FAIL %s L%0d valid_cycle[%0d]: got %0d want %0d", nm, LAT[i], nv[i], cyc, d + LAT[i] + nv[i]);
          end
          nv[i]++;
        end
        if (od[i] && !seen[i]) begin
          seen[i] = 1'b1;
          n_cmp++;
          if (cyc != d + n + LAT[i] || nv[i] != n) begin
            n_err++;
            $display("FAIL %s L%0d done: got cycle %0d after %0d valids want cycle %0d after %0d",
                     nm, LAT[i], cyc, nv[i], d + n + LAT[i], n);
          end
          n_cmp++;
          if (ob[i] !== 1'b0 || oa[i] !== 32'h0) begin
            n_err++;
            $display("FAIL %s L%0d idle_at_done: got busy=%b act=%h want 0/0", nm, LAT[i], ob[i], oa[i]);
          end
        end
      end
      tick();
    end
    n_cmp++;
    if (seen != 3'b111) begin
      n_err++;
      $display("FAIL %s timeout: done seen %b want 111", nm, seen);
    end
  endtask

  task automatic test_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ordy[i] !== 1'b0 || ov[i] !== 1'b0 || ob[i] !== 1'b0 || od[i] !== 1'b0 ||
          om[i] !== 32'h43800000 || oa[i] !== 32'h0) begin
        n_err++;
        $display("FAIL reset L%0d: got rdy=%b vld=%b busy=%b done=%b max=%h act=%h want 0/0/0/0/43800000/0",
                 LAT[i], ordy[i], ov[i], ob[i], od[i], om[i], oa[i]);
      end
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (ob !== 3'b000 || ordy !== 3'b000) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b ready=%b want 000/000", ob, ordy);
    end
  endtask

  task automatic test_basic();
    tile    = '{int2f(33), 32'h3F000000, int2f(1), int2f(255), int2f(256)};
    exp_idx = '{8'd33, 8'd0, 8'd1, 8'd255, 8'd255};
    run_tile("basic", 32'h43800000, 1'b0, 1'b1);
  endtask

  task automatic test_scale();
    tile    = '{int2f(3), int2f(8), int2f(255), int2f(257), int2f(561)};
    exp_idx = '{8'd1, 8'd3, 8'd116, 8'd117, 8'd255};
    run_tile("scale", 32'h440C4000, 1'b0, 1'b1);
  endtask

  task automatic test_special();
    tile    = '{32'hBF800000, 32'h7F800000, 32'h40000000};
    exp_idx = '{8'd0, 8'd255, 8'd255};
    run_tile("special", 32'h40000000, 1'b0, 1'b1);
  endtask

  task automatic test_zero();
    tile    = '{32'h0, 32'h0, 32'h0, 32'h0};
    exp_idx = '{8'd0, 8'd0, 8'd0, 8'd0};
    run_tile("zero", 32'h43800000, 1'b0, 1'b1);
  endtask

  task automatic test_full_depth();
    tile.delete();
    exp_idx.delete();
    for (int v = 1; v <= DEPTH; v++) begin
      tile.push_back(int2f(v));
      exp_idx.push_back((v * 16 > 255) ? 8'd255 : 8'(v * 16));
    end
    run_tile("full_depth", 32'h41800000, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid = 1'b1; act = int2f(k + 10); last = (k == 4);
      tick();
    end
    valid = 1'b0; last = 1'b0; act = '0;
    tick();
    tick();
    n_cmp++;
    if (ov[0] !== 1'b1 || ob !== 3'b111) begin
      n_err++;
      $display("FAIL rst_mid pre: got vld0=%b busy=%b want 1/111", ov[0], ob);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ov !== 3'b000 || ob !== 3'b000 || od !== 3'b000) begin
      n_err++;
      $display("FAIL rst_mid immediate: got vld=%b busy=%b done=%b want 000/000/000", ov, ob, od);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++;
      if (ov !== 3'b000 || od !== 3'b000) begin
        n_err++;
        $display("FAIL rst_mid quiet: got vld=%b done=%b want 000/000", ov, od);
      end
    end
    for (int i = 0; i < 3; i++) sb[i].delete();
    tile    = '{32'h3F800000};
    exp_idx = '{8'd255};
    run_tile("after_reset", 32'h3F800000, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    test_scale();
    test_basic();
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_scale();
    test_special();
    test_zero();
    test_full_depth();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
